ucsbece154b_bpu_ctrl: RTL

Branch-prediction sequencing controller for the 5-stage pipeline. Carries each fetch-time prediction (taken bit, predicted target, PHT index) alongside its instruction through the D and E stages. In E it compares the prediction with the resolved outcome, then generates the redirect PC, the mispredict flushes and the PHT/GHR/BTB update strobes for the branch predictor. Sits between fetch, the hazard unit and the branch predictor; it replaces the ad-hoc E-stage update logic.

---
 rtl/ucsbece154b_bpu_ctrl_pkg.sv | 18 +
 rtl/ucsbece154b_bpu_ctrl_if.sv | 46 ++++
 rtl/ucsbece154b_bpu_tagreg.sv | 24 ++
 rtl/ucsbece154b_bpu_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ucsbece154b_bpu_ctrl_pkg.sv
// Shared widths and helpers for the branch-prediction sequencing controller.
// Predicate helpers keep control/taken decoding in one place.
package ucsbece154b_bpu_ctrl_pkg;

    localparam int PHT_AW_DEF = 6;
    localparam int BTB_IW_DEF = 6;
    localparam int CNT_W_DEF  = 32;

    function automatic logic is_ctl(input logic br, input logic jal, input logic jalr);
        return br | jal | jalr;
    endfunction

    function automatic logic act_taken(input logic br, input logic jal, input logic jalr,
                                       input logic cond);
        return jal | jalr | (br & cond);
    endfunction

endpackage

// File: rtl/ucsbece154b_bpu_ctrl_if.sv
// Fetch/E-stage/predictor-update bundle of the BPU controller; master = pipeline, slave = controller.
// Purely combinational wiring, no flow control.
interface ucsbece154b_bpu_ctrl_if #(
    parameter int PHT_AW = 6,
    parameter int BTB_IW = 6
);
    logic              StallD_i;
    logic              FlushD_i;
    logic              FlushE_i;
    logic              PredTakenF_i;
    logic [31:0]       PredTargetF_i;
    logic [PHT_AW-1:0] PHTidxF_i;
    logic              BranchE_i;
    logic              JalE_i;
    logic              JalrE_i;
    logic              CondTakenE_i;
    logic [31:0]       PCE_i;
    logic [31:0]       PCTargetE_i;
    logic [31:0]       PCPlus4E_i;
    logic              RedirectE_o;
    logic [31:0]       RedirectPCE_o;
    logic              FlushD_o;
    logic              FlushE_o;
    logic              PHTwe_o;
    logic              PHTinc_o;
    logic [PHT_AW-1:0] PHTwaddr_o;
    logic              GHRreset_o;
    logic              BTBwe_o;
    logic [BTB_IW-1:0] BTBwaddr_o;
    logic [31:0]       BTBwdata_o;

    modport master (
        output StallD_i, FlushD_i, FlushE_i, PredTakenF_i, PredTargetF_i, PHTidxF_i,
               BranchE_i, JalE_i, JalrE_i, CondTakenE_i, PCE_i, PCTargetE_i, PCPlus4E_i,
        input  RedirectE_o, RedirectPCE_o, FlushD_o, FlushE_o, PHTwe_o, PHTinc_o,
               PHTwaddr_o, GHRreset_o, BTBwe_o, BTBwaddr_o, BTBwdata_o
    );

    modport slave (
        input  StallD_i, FlushD_i, FlushE_i, PredTakenF_i, PredTargetF_i, PHTidxF_i,
               BranchE_i, JalE_i, JalrE_i, CondTakenE_i, PCE_i, PCTargetE_i, PCPlus4E_i,
        output RedirectE_o, RedirectPCE_o, FlushD_o, FlushE_o, PHTwe_o, PHTinc_o,
               PHTwaddr_o, GHRreset_o, BTBwe_o, BTBwaddr_o, BTBwdata_o
    );

endinterface

// File: rtl/ucsbece154b_bpu_tagreg.sv
// One prediction-tag pipeline stage; 1-cycle latency, flush beats stall, stall holds contents.
module ucsbece154b_bpu_tagreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         stall_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i)
            q_q <= '0;
        else if (!stall_i)
            q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/ucsbece154b_bpu_ctrl.sv
// Carries fetch predictions through D/E and resolves them in E: zero-latency redirect, flush and predictor updates.
// Optional perf counters under `BPU_PERF_EN`; no backpressure beyond the D-stage stall.
module ucsbece154b_bpu_ctrl
    import ucsbece154b_bpu_ctrl_pkg::*;
#(
    parameter int PHT_AW = PHT_AW_DEF,
    parameter int BTB_IW = BTB_IW_DEF
`ifdef BPU_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    ucsbece154b_bpu_ctrl_if.slave bpu
`ifdef BPU_PERF_EN
    ,
    output logic [CNT_W-1:0] ctl_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] btb_wr_cnt_o
`endif
);

    typedef struct packed {
        logic              v;
        logic              t;
        logic [31:0]       tgt;
        logic [PHT_AW-1:0] idx;
    } tag_t;

    tag_t tag_f, tag_d, tag_e;

    assign tag_f = '{v: 1'b1, t: bpu.PredTakenF_i, tgt: bpu.PredTargetF_i, idx: bpu.PHTidxF_i};

    ucsbece154b_bpu_tagreg #(.W($bits(tag_t))) u_tag_d (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bpu.FlushD_i),
        .stall_i (bpu.StallD_i),
        .d_i     (tag_f),
        .q_o     (tag_d)
    );

    ucsbece154b_bpu_tagreg #(.W($bits(tag_t))) u_tag_e (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bpu.FlushE_i),
        .stall_i (1'b0),
        .d_i     (tag_d),
        .q_o     (tag_e)
    );

    logic live, ctl, act_t, tgt_diff, mispred;

    // reset gates outputs combinationally so a mispredict in E is silenced on the reset cycle itself
    assign live     = tag_e.v & ~reset;
    assign ctl      = is_ctl(bpu.BranchE_i, bpu.JalE_i, bpu.JalrE_i);
    assign act_t    = act_taken(bpu.BranchE_i, bpu.JalE_i, bpu.JalrE_i, bpu.CondTakenE_i);
    assign tgt_diff = (tag_e.tgt != bpu.PCTargetE_i);
    assign mispred  = (act_t != tag_e.t) | (act_t & tag_e.t & tgt_diff);

    wire unused_pc_bits = ^{bpu.PCE_i[31:BTB_IW+2], bpu.PCE_i[1:0]};

    always_comb begin
        bpu.RedirectE_o   = 1'b0;
        bpu.RedirectPCE_o = '0;
        bpu.PHTwe_o       = 1'b0;
        bpu.PHTinc_o      = 1'b0;
        bpu.PHTwaddr_o    = '0;
        bpu.GHRreset_o    = 1'b0;
        bpu.BTBwe_o       = 1'b0;
        bpu.BTBwaddr_o    = '0;
        bpu.BTBwdata_o    = '0;
        if (live) begin
            bpu.RedirectE_o   = mispred;
            bpu.RedirectPCE_o = act_t ? bpu.PCTargetE_i : bpu.PCPlus4E_i;
            bpu.PHTwe_o       = bpu.BranchE_i;
            bpu.PHTinc_o      = bpu.CondTakenE_i;
            bpu.PHTwaddr_o    = tag_e.idx;
            bpu.GHRreset_o    = bpu.BranchE_i & (bpu.CondTakenE_i != tag_e.t);
            // a correct BTB hit never rewrites its entry
            bpu.BTBwe_o       = act_t & (~tag_e.t | tgt_diff);
            bpu.BTBwaddr_o    = bpu.PCE_i[BTB_IW+1:2];
            bpu.BTBwdata_o    = bpu.PCTargetE_i;
        end
    end

    assign bpu.FlushD_o = bpu.RedirectE_o;
    assign bpu.FlushE_o = bpu.RedirectE_o;

`ifdef BPU_PERF_EN
    logic [CNT_W-1:0] ctl_cnt_q, mispred_cnt_q, btb_wr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_cnt_q     <= '0;
            mispred_cnt_q <= '0;
            btb_wr_cnt_q  <= '0;
        end else begin
            if (live && ctl && ctl_cnt_q != '1)
                ctl_cnt_q <= ctl_cnt_q + 1'b1;
            if (bpu.RedirectE_o && mispred_cnt_q != '1)
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            if (bpu.BTBwe_o && btb_wr_cnt_q != '1)
                btb_wr_cnt_q <= btb_wr_cnt_q + 1'b1;
        end
    end

    assign ctl_cnt_o     = ctl_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
    assign btb_wr_cnt_o  = btb_wr_cnt_q;
`endif

endmodule
